// File: rtl/carry_slice_sequencer_pkg.sv
// Shared types and defaults for the carry-slice sequencer: FSM state encoding,
// default widths and the index-width helper.
package carry_slice_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice index counter width; a single-slice configuration still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/carry_slice_sequencer_if.sv
// Operand/result handshake bundle for the carry-slice sequencer; master drives
// operands and out_ready, slave is the sequencer.
interface carry_slice_sequencer_if
    import carry_slice_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/carry_slice_sequencer_cla8_slice.sv
// SLICE-bit carry-lookahead adder slice: generate/propagate prefix terms give
// every internal carry directly from g, p and cin.
module cla8_slice
    import carry_slice_sequencer_pkg::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_carry_msb,
    output logic             o_cout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit
    always_comb begin
        logic v_acc;
        logic v_prod;
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        w_c    = '0;
        v_acc  = 1'b0;
        v_prod = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < SLICE; i++) begin
            v_acc  = w_g[i];
            v_prod = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                v_acc  = v_acc | (v_prod & w_g[j]);
                v_prod = v_prod & w_p[j];
            end
            w_c[i+1] = v_acc | (v_prod & i_cin);
        end
    end

    assign o_sum       = w_p ^ w_c[SLICE-1:0];
    assign o_carry_msb = w_c[SLICE-1];
    assign o_cout      = w_c[SLICE];

endmodule

// File: rtl/carry_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract reusing one SLICE-bit lookahead slice per cycle.
// Optional macro CARRY_SLICE_EARLY_EXIT_EN finishes as soon as the upper slices are provably zero.
module carry_slice_sequencer
    import carry_slice_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input logic               clock,
    input logic               reset,
    carry_slice_sequencer_if.slave bus
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = idx_width(N);

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("carry_slice_sequencer: WIDTH must be a multiple of SLICE");
    end

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_in_ready;

    int               w_base;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_s_sum;
    logic             w_s_carry_msb;
    logic             w_s_cout;
    logic             w_last;
    logic             w_early_exit;
    logic             w_accept;

    assign w_base    = int'(r_idx) * SLICE;
    assign w_a_slice = r_a[w_base +: SLICE];
    assign w_b_slice = r_b[w_base +: SLICE];
    assign w_last    = (r_idx == IDXW'(N - 1));
    assign w_accept  = bus.in_valid && r_in_ready;

    cla8_slice #(.SLICE(SLICE)) u_slice (
        .i_a         (w_a_slice),
        .i_b         (w_b_slice),
        .i_cin       (r_carry),
        .o_sum       (w_s_sum),
        .o_carry_msb (w_s_carry_msb),
        .o_cout      (w_s_cout)
    );

`ifdef CARRY_SLICE_EARLY_EXIT_EN
    logic [WIDTH-1:0] w_upper;

    // With no carry and all-zero operand bits above, the remaining sum, cout and ovf are all 0.
    assign w_upper      = (r_a | r_b) >> ((int'(r_idx) + 1) * SLICE);
    assign w_early_exit = !w_last && !w_s_cout && (w_upper == '0);
`else
    assign w_early_exit = 1'b0;
`endif

    // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b ^ {WIDTH{bus.in_sub}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_carry    <= bus.in_sub ? 1'b1 : bus.in_cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: SLICE] <= w_s_sum;
                    r_carry                <= w_s_cout;
                    r_idx                  <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_cout      <= w_s_cout;
                        r_ovf       <= w_s_carry_msb ^ w_s_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_early_exit) begin
                        r_cout      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.busy      = r_busy;

endmodule
